// File: rtl/ledstrip_fifo_driver.sv
// ledstrip_fifo_driver: register-mapped pixel FIFO feeding a WS2812-style
// one-wire serializer with NUM_CH selectable strip outputs on uo_out[NUM_CH:1].
// Optional feature macro: LEDSTRIP_BRIGHTNESS_EN (brightness scaling at pop time).
module ledstrip_fifo_driver #(
    parameter int unsigned CLOCK_MHZ  = 64,
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    // Bit timing in clock cycles
    localparam int unsigned T0H   = CLOCK_MHZ * 400 / 1000;
    localparam int unsigned T1H   = CLOCK_MHZ * 800 / 1000;
    localparam int unsigned TBIT  = CLOCK_MHZ * 1250 / 1000;
    localparam int unsigned TRST  = CLOCK_MHZ * 60;

    localparam int unsigned CNT_W = $clog2(TRST + 1);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned REP_W = 7;
    localparam int unsigned IDX_W = 5;

    localparam logic [3:0] A_STATUS = 4'h0;
    localparam logic [3:0] A_R      = 4'h1;
    localparam logic [3:0] A_G      = 4'h2;
    localparam logic [3:0] A_B      = 4'h3;
    localparam logic [3:0] A_PUSH   = 4'h4;
    localparam logic [3:0] A_CHSEL  = 4'h5;
    localparam logic [3:0] A_BRIGHT = 4'h6;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
        logic [2:0] ch;
        logic [5:0] count;
        logic       latch;
    } entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_BIT_HIGH,
        S_BIT_LOW,
        S_LATCH
    } state_t;

    // Staging registers
    logic [7:0] r_q, g_q, b_q;
    logic [2:0] chsel_q;
    logic [7:0] bright_rd;
    logic       overflow_q;

    // FIFO storage and pointers
    entry_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]   level_q;

    // Serializer state
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic [23:0]        pix_q, pix_d;
    logic [2:0]         ch_q, ch_d;
    logic               latch_q, latch_d;
    logic [7:0]         uo_d;

    logic       wr_cmd, flush, clr_ovf, push_req, push_ok, pop;
    logic       full, empty, idle;
    entry_t     push_entry, head;
    logic [7:0] head_g, head_r, head_b;
    logic [2:0] head_ch;
    logic [CNT_W-1:0] hi_last, lo_last;
    logic       unused_ui;

    assign unused_ui = ^ui_in;

    assign wr_cmd   = data_write && (address == A_STATUS);
    assign flush    = wr_cmd && data_in[1];
    assign clr_ovf  = wr_cmd && data_in[0];
    assign push_req = data_write && (address == A_PUSH);

    assign full     = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty    = (level_q == '0);
    assign push_ok  = push_req && !full && !flush;
    assign pop      = (state_q == S_LOAD) && !empty && !flush;
    assign idle     = empty && (state_q == S_IDLE);

    assign push_entry = '{g: g_q, r: r_q, b: b_q, ch: chsel_q,
                          count: data_in[5:0], latch: data_in[7]};
    assign head       = mem[rd_ptr_q];
    assign head_ch    = (head.ch < 3'(NUM_CH)) ? head.ch : 3'd0;

`ifdef LEDSTRIP_BRIGHTNESS_EN
    logic [7:0] bright_q;

    // Scale one colour component by (BRIGHT+1)/256
    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] br);
        logic [16:0] p;
        p = 17'(c) * (17'(br) + 17'd1);
        return p[15:8];
    endfunction

    // Brightness register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bright_q <= 8'hFF;
        end else if (data_write && (address == A_BRIGHT)) begin
            bright_q <= data_in;
        end
    end

    assign bright_rd = bright_q;
    assign head_g    = scale(head.g, bright_q);
    assign head_r    = scale(head.r, bright_q);
    assign head_b    = scale(head.b, bright_q);
`else
    assign bright_rd = 8'h00;
    assign head_g    = head.g;
    assign head_r    = head.r;
    assign head_b    = head.b;
`endif

    // Colour / channel staging registers; only later pushes see new values
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q     <= 8'h00;
            g_q     <= 8'h20;
            b_q     <= 8'h00;
            chsel_q <= 3'd0;
        end else if (data_write) begin
            case (address)
                A_R:     r_q     <= data_in;
                A_G:     g_q     <= data_in;
                A_B:     b_q     <= data_in;
                A_CHSEL: chsel_q <= data_in[2:0];
                default: ;
            endcase
        end
    end

    // Sticky overflow flag: set on a push into a full FIFO
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (push_req && full && !flush) begin
            overflow_q <= 1'b1;
        end else if (clr_ovf) begin
            overflow_q <= 1'b0;
        end
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_entry;
        end
    end

    // FIFO pointers and fill level; flush empties the queue
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q <= level_q + LVL_W'(push_ok) - LVL_W'(pop);
        end
    end

    // High/low phase terminal counts for the bit currently being sent
    assign hi_last = pix_q[bit_idx_q] ? CNT_W'(T1H - 1) : CNT_W'(T0H - 1);
    assign lo_last = pix_q[bit_idx_q] ? CNT_W'(TBIT - T1H - 1) : CNT_W'(TBIT - T0H - 1);

    // Serializer next-state and output decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        rep_d     = rep_q;
        pix_d     = pix_q;
        ch_d      = ch_q;
        latch_d   = latch_q;
        uo_d      = 8'h00;

        unique case (state_q)
            S_IDLE: begin
                if (!empty) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (empty) begin
                    state_d = S_IDLE;
                end else begin
                    pix_d     = {head_g, head_r, head_b};
                    ch_d      = head_ch;
                    rep_d     = (head.count == 6'd0) ? 7'd64 : {1'b0, head.count};
                    latch_d   = head.latch;
                    bit_idx_d = 5'd23;
                    cnt_d     = '0;
                    state_d   = S_BIT_HIGH;
                end
            end
            S_BIT_HIGH: begin
                if (cnt_q == hi_last) begin
                    cnt_d   = '0;
                    state_d = S_BIT_LOW;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_BIT_LOW: begin
                if (cnt_q == lo_last) begin
                    cnt_d = '0;
                    if (bit_idx_q != 5'd0) begin
                        bit_idx_d = bit_idx_q - 5'd1;
                        state_d   = S_BIT_HIGH;
                    end else if (rep_q != 7'd1) begin
                        rep_d     = rep_q - 7'd1;
                        bit_idx_d = 5'd23;
                        state_d   = S_BIT_HIGH;
                    end else if (latch_q) begin
                        state_d = S_LATCH;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_LATCH: begin
                if (cnt_q == CNT_W'(TRST - 1)) begin
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush aborts the current entry and forces a reset gap
        if (flush) begin
            state_d = S_LATCH;
            cnt_d   = '0;
        end

        if (state_d == S_BIT_HIGH) begin
            uo_d = 8'b0000_0010 << ch_d;
        end
    end

    // Serializer state, datapath and output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            rep_q     <= '0;
            pix_q     <= '0;
            ch_q      <= '0;
            latch_q   <= 1'b0;
            uo_out    <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            rep_q     <= rep_d;
            pix_q     <= pix_d;
            ch_q      <= ch_d;
            latch_q   <= latch_d;
            uo_out    <= uo_d;
        end
    end

    // Register read mux
    always_comb begin
        data_out = 8'h00;
        case (address)
            A_STATUS: data_out = {4'(level_q), 1'b0, overflow_q, full, idle};
            A_R:      data_out = r_q;
            A_G:      data_out = g_q;
            A_B:      data_out = b_q;
            A_CHSEL:  data_out = {5'b0, chsel_q};
            A_BRIGHT: data_out = bright_rd;
            default:  data_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_ledstrip_fifo_driver.sv
// Scoreboard bench for ledstrip_fifo_driver (64 MHz, 2 channels, 4-deep FIFO).
// Pixel pushes queue expected pulses; a monitor measures each strip pulse.
module tb_ledstrip_fifo_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uo_out;
    logic [3:0] address = 4'h0;
    logic       data_write = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;

    always #5 clk = ~clk;

    ledstrip_fifo_driver #(
        .CLOCK_MHZ (64),
        .NUM_CH    (2),
        .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ui_in     (ui_in),
        .uo_out    (uo_out),
        .address   (address),
        .data_write(data_write),
        .data_in   (data_in),
        .data_out  (data_out)
    );

    typedef struct {
        int ch;
        int hi;
        int gap;
    } pulse_t;

    pulse_t     exp_q[$];
    pulse_t     mon_e;
    int         n_assert = 0;
    int         n_fail = 0;
    int         stray = 0;
    int         bright_m = 255;
    bit         ignore = 1'b0;

`ifdef LEDSTRIP_BRIGHTNESS_EN
    localparam bit BR_EN = 1'b1;
`else
    localparam bit BR_EN = 1'b0;
`endif

    task automatic check(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int sc(input int c);
        if (BR_EN) return (c * (bright_m + 1)) >> 8;
        return c;
    endfunction

    // Queue the pulses one pixel entry should produce
    task automatic expect_entry(input int g, input int r, input int b, input int ch, input int cnt);
        logic [23:0] pix;
        logic [7:0]  cg, cr, cb;
        int          reps, prev_hi;
        bit          first;
        pulse_t      p;
        cg = 8'(sc(g));
        cr = 8'(sc(r));
        cb = 8'(sc(b));
        pix = {cg, cr, cb};
        reps = (cnt == 0) ? 64 : cnt;
        first = 1'b1;
        prev_hi = 0;
        for (int k = 0; k < reps; k++) begin
            for (int i = 23; i >= 0; i--) begin
                p.ch  = ch;
                p.hi  = pix[i] ? 51 : 25;
                p.gap = first ? 0 : 80 - prev_hi;
                exp_q.push_back(p);
                prev_hi = p.hi;
                first = 1'b0;
            end
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        address = a;
        data_in = d;
        data_write = 1'b1;
        @(negedge clk);
        data_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        address = a;
        #1;
        d = data_out;
    endtask

    task automatic wait_drain(input string name, input int max);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL %s: %0d pulses missing after %0d cycles", name, exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    task automatic wait_active(input string name);
        int n;
        n = 0;
        while (uo_out[2:1] == 2'b00 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (uo_out[2:1] == 2'b00) begin
            n_assert++;
            n_fail++;
            $display("FAIL %s: no strip activity got 0x00 expected nonzero", name);
        end
    endtask

    task automatic count_to_idle(input int max, output int n);
        address = 4'h0;
        n = 0;
        #1;
        while (data_out[0] !== 1'b1 && n < max) begin
            @(negedge clk);
            #1;
            n++;
        end
    endtask

    // Pulse monitor: measures high width, preceding low gap and channel
    int         hi_cnt = 0;
    int         lo_cnt = 0;
    int         cur_ch = 0;
    int         cur_gap = 0;
    logic [7:0] prev = 8'h00;

    always @(posedge clk) begin
        #1;
        if ((uo_out & 8'hF9) != 8'h00 || $countones(uo_out) > 1) stray++;
        if (uo_out[2:1] != 2'b00) begin
            if (prev[2:1] == 2'b00) begin
                cur_gap = lo_cnt;
                cur_ch  = uo_out[2] ? 1 : 0;
                hi_cnt  = 1;
            end else begin
                hi_cnt++;
            end
        end else begin
            if (prev[2:1] != 2'b00) begin
                if (!ignore) begin
                    n_assert++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL pulse: got ch%0d hi %0d, expected no pulse", cur_ch, hi_cnt);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (cur_ch != mon_e.ch || hi_cnt != mon_e.hi ||
                            (mon_e.gap != 0 && cur_gap != mon_e.gap)) begin
                            n_fail++;
                            $display("FAIL pulse: got ch%0d hi %0d gap %0d, expected ch%0d hi %0d gap %0d",
                                     cur_ch, hi_cnt, cur_gap, mon_e.ch, mon_e.hi, mon_e.gap);
                        end
                    end
                end
                lo_cnt = 1;
            end else begin
                lo_cnt++;
            end
        end
        prev = uo_out;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int         n;

        // Reset state and register defaults
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset uo_out", int'(uo_out), 0);
        rst_n = 1'b1;
        rd(4'h0, d); check("reset status", int'(d), 8'h01);
        rd(4'h1, d); check("reset R", int'(d), 8'h00);
        rd(4'h2, d); check("reset G", int'(d), 8'h20);
        rd(4'h3, d); check("reset B", int'(d), 8'h00);
        rd(4'h5, d); check("reset CHSEL", int'(d), 8'h00);
        rd(4'h6, d); check("reset BRIGHT", int'(d), BR_EN ? 8'hFF : 8'h00);
        rd(4'h9, d); check("unmapped read", int'(d), 8'h00);

        // Single pixel G=0x80 with latch, then exact latch-to-idle time
        wr(4'h2, 8'h80);
        expect_entry(8'h80, 0, 0, 0, 1);
        wr(4'h4, 8'h81);
        wait_drain("single pixel", 3000);
        count_to_idle(5000, n);
        check("latch to idle cycles", n, 55 + 3840 + 1);
        rd(4'h0, d); check("idle after latch", int'(d), 8'h01);

        // Flush mid-bit with a second entry still queued
        ignore = 1'b1;
        wr(4'h2, 8'hAA);
        wr(4'h4, 8'h01);
        wr(4'h4, 8'h02);
        wait_active("flush start");
        repeat (10) @(negedge clk);
        wr(4'h0, 8'h02);
        check("flush uo_out", int'(uo_out), 0);
        #1;
        check("flush status", int'(data_out), 8'h00);
        count_to_idle(5000, n);
        check("flush latch cycles", n, 3841);
        ignore = 1'b0;

        // Overflow: one busy entry, then five pushes into a 4-deep FIFO
        wr(4'h2, 8'h11);
        wr(4'h1, 8'h22);
        wr(4'h3, 8'h33);
        expect_entry(8'h11, 8'h22, 8'h33, 0, 2);
        wr(4'h4, 8'h02);
        wait_active("overflow busy");
        for (int i = 0; i < 5; i++) begin
            wr(4'h2, 8'(8'h40 + i));
            if (i < 4) expect_entry(8'h40 + i, 8'h22, 8'h33, 0, 1);
            wr(4'h4, 8'h01);
        end
        rd(4'h0, d); check("overflow status", int'(d), 8'h46);
        wr(4'h0, 8'h01);
        rd(4'h0, d); check("overflow cleared", int'(d), 8'h42);
        wait_drain("overflow drain", 20000);
        repeat (100) @(negedge clk);
        rd(4'h0, d); check("idle after overflow", int'(d), 8'h01);

        // Channel 1, three repeats with latch
        wr(4'h5, 8'h01);
        wr(4'h2, 8'h5A);
        wr(4'h1, 8'hC3);
        wr(4'h3, 8'h0F);
        expect_entry(8'h5A, 8'hC3, 8'h0F, 1, 3);
        wr(4'h4, 8'h83);
        wait_drain("channel 1 x3", 8000);
        repeat (4000) @(negedge clk);
        rd(4'h0, d); check("idle after ch1", int'(d), 8'h01);

        // Out-of-range CHSEL maps to channel 0
        wr(4'h5, 8'h05);
        rd(4'h5, d); check("CHSEL readback", int'(d), 8'h05);
        wr(4'h2, 8'h01);
        wr(4'h1, 8'h80);
        wr(4'h3, 8'h00);
        expect_entry(8'h01, 8'h80, 8'h00, 0, 1);
        wr(4'h4, 8'h01);
        wait_drain("chsel fallback", 3000);
        repeat (100) @(negedge clk);

        // Brightness 0x7F applied to G=0xFF
        wr(4'h5, 8'h00);
        wr(4'h6, 8'h7F);
        bright_m = 8'h7F;
        rd(4'h6, d); check("BRIGHT readback", int'(d), BR_EN ? 8'h7F : 8'h00);
        wr(4'h2, 8'hFF);
        wr(4'h1, 8'h00);
        wr(4'h3, 8'h00);
        expect_entry(8'hFF, 0, 0, 0, 1);
        wr(4'h4, 8'h01);
        wait_drain("brightness", 3000);
        repeat (100) @(negedge clk);

        // Reset in the middle of LATCH
        wr(4'h2, 8'h80);
        expect_entry(8'h80, 0, 0, 0, 1);
        wr(4'h4, 8'h81);
        wait_drain("pre-reset pixel", 3000);
        repeat (200) @(negedge clk);
        rst_n = 1'b0;
        bright_m = 255;
        @(negedge clk);
        check("reset mid-latch uo_out", int'(uo_out), 0);
        rst_n = 1'b1;
        rd(4'h0, d); check("status after latch reset", int'(d), 8'h01);
        rd(4'h2, d); check("G after reset", int'(d), 8'h20);

        // Reset in the middle of a high phase
        ignore = 1'b1;
        wr(4'h4, 8'h81);
        wait_active("pre-reset bit");
        rst_n = 1'b0;
        @(negedge clk);
        check("reset mid-bit uo_out", int'(uo_out), 0);
        rst_n = 1'b1;
        rd(4'h0, d); check("status after bit reset", int'(d), 8'h01);
        repeat (5) @(negedge clk);
        check("quiet after bit reset", int'(uo_out), 0);
        ignore = 1'b0;

        check("scoreboard empty", exp_q.size(), 0);
        check("stray output bits", stray, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ledstrip_fifo_driver.md
LEDSTRIP_FIFO_DRIVER -- requirements
Module: ledstrip_fifo_driver

Interface
REQ-001 SHALL have parameter CLOCK_MHZ, default 64, integer clock frequency in MHz used for all bit timing.
REQ-002 SHALL have parameter NUM_CH, default 2, number of strip outputs, legal range 1..7.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, pixel FIFO entries, power of two, 2..16.
REQ-004 SHALL have port clk  input  1  clock; reset rst_n, synchronous, active-low; clock clk.
REQ-005 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-006 SHALL have port ui_in  input  8  unused.
REQ-007 SHALL have port uo_out  output  8  bit k+1 = strip channel k; all other bits 0.
REQ-008 SHALL have port address  input  4  register address.
REQ-009 SHALL have port data_write  input  1  single-cycle write strobe.
REQ-010 SHALL have port data_in  input  8  write data.
REQ-011 SHALL have port data_out  output  8  read data, combinational from address.

Function
REQ-012 SHALL decode registers: 0x0 STATUS/CMD, 0x1 R, 0x2 G, 0x3 B, 0x4 PUSH, 0x5 CHSEL, 0x6 BRIGHT; other addresses read 0x00 and ignore writes.
REQ-013 SHALL read STATUS as {level[3:0], 1'b0, overflow, full, idle}; idle = FIFO empty and FSM in IDLE.
REQ-014 SHALL on CMD write: bit0 clears overflow; bit1 flushes FIFO, aborts current entry, drives outputs low, enters LATCH.
REQ-015 SHALL on PUSH write enqueue {G,R,B, CHSEL[2:0], count=data_in[5:0], latch=data_in[7]}; count 0 means 64.
REQ-016 SHALL accept a push iff level < FIFO_DEPTH at start of cycle; otherwise drop it and set overflow (sticky).
REQ-017 SHALL allow push and pop in the same cycle, both taking effect; flush in the same cycle as push wins and the push is dropped.
REQ-018 SHALL implement FSM IDLE -> LOAD -> BIT_HIGH -> BIT_LOW -> (next bit | next repeat | LATCH | LOAD | IDLE).
REQ-019 SHALL in LOAD pop the head entry when FIFO non-empty; stay in IDLE when empty.
REQ-020 SHALL shift 24 bits MSB first, order G7..G0, R7..R0, B7..B0, repeating the same pixel count times.
REQ-021 SHALL use cycle counts T0H=CLOCK_MHZ*400/1000, T1H=CLOCK_MHZ*800/1000, TBIT=CLOCK_MHZ*1250/1000, TRST=CLOCK_MHZ*60, integer truncation (64 MHz: 25/51/80/3840).
REQ-022 SHALL drive the selected channel high for T0H/T1H then low for the rest of TBIT; unselected channels held low.
REQ-023 SHALL after the last repeat of an entry with latch=1 hold all outputs low TRST cycles in LATCH, then go to LOAD.
REQ-024 SHALL with latch=0 proceed to LOAD immediately; an empty FIFO at that point goes to IDLE, outputs low.
REQ-025 SHALL treat CHSEL >= NUM_CH as channel 0.
REQ-026 SHALL apply staging-register writes only to later pushes; queued entries are unaffected.

Reset
REQ-027 SHALL on rst_n low: FIFO empty, overflow 0, FSM IDLE, uo_out 0x00 next edge, R=0x00, G=0x20, B=0x00, CHSEL=0, BRIGHT=0xFF.
REQ-028 SHALL abort any in-flight bit immediately on reset, without completing TBIT or TRST.

Configuration
REQ-029 SHALL with LEDSTRIP_BRIGHTNESS_EN defined scale each component at pop time as (c*(BRIGHT+1))>>8, 8-bit result.
REQ-030 SHALL without LEDSTRIP_BRIGHTNESS_EN read BRIGHT as 0x00, ignore writes, send colors unscaled.

Verification
REQ-031 SHALL cover: reset, G=0x80,R=0,B=0, PUSH 0x81 -> ch0 one 51-cycle high pulse then 23 of 25 cycles, then 3840 low, idle=1.
REQ-032 SHALL cover: five pushes with FIFO_DEPTH=4 while busy -> fifth dropped, overflow=1, CMD 0x01 clears it.
REQ-033 SHALL cover: CHSEL=1, PUSH count 3 -> 72 bits on uo_out[2], uo_out[1] stays 0.
REQ-034 SHALL cover: CMD 0x02 mid-bit -> outputs low next cycle, level=0, 3840-cycle latch, then idle.
REQ-035 SHALL cover: BRIGHT=0x7F, G=0xFF with macro -> G sent as 0x7F; without macro -> 0xFF.
REQ-036 SHALL cover: rst_n low mid-LATCH -> uo_out 0x00, STATUS 0x01 after release.
